// File: rtl/cpu_run_pkg.sv
// Shared types and default parameter values for the CPU run controller.
package cpu_run_pkg;

  localparam int DEF_NUM_CPUS       = 2;
  localparam int DEF_TIMEOUT_CYCLES = 40;
  localparam int DEF_RESET_CYCLES   = 2;
  localparam int DEF_START_WAIT     = 4;
  localparam int DEF_CNT_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } run_state_e;

  // A new run may only be launched once the previous one is over.
  function automatic logic can_start(run_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// Control/status bundle between a run supervisor (master) and the controller (slave).
interface cpu_run_controller_if
  import cpu_run_pkg::*;
#(
  parameter int NUM_CPUS = DEF_NUM_CPUS,
  parameter int CNT_W    = DEF_CNT_W
);

  logic                      start;
  logic                      abort;
  logic                      pause;
  logic [NUM_CPUS-1:0]       active;
  logic [32*NUM_CPUS-1:0]    register_v0;
  logic                      cpu_rst;
  logic                      clk_enable;
  logic [NUM_CPUS-1:0]       finished;
  logic [32*NUM_CPUS-1:0]    v0_capt;
  logic [CNT_W*NUM_CPUS-1:0] cyc_capt;
  logic                      done;
  logic                      timeout;
  logic                      start_err;

  modport master (
    output start, abort, pause, active, register_v0,
    input  cpu_rst, clk_enable, finished, v0_capt, cyc_capt, done, timeout, start_err
  );

  modport slave (
    input  start, abort, pause, active, register_v0,
    output cpu_rst, clk_enable, finished, v0_capt, cyc_capt, done, timeout, start_err
  );

endinterface

// File: rtl/run_channel_monitor.sv
// Per-CPU completion tracker: falling-edge detect on active, seen-active flag,
// sticky finished flag and capture of v0 / cycle count at completion.
module run_channel_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample,
  input  logic             start_chk,
  input  logic             active,
  input  logic [31:0]      v0,
  input  logic [CNT_W-1:0] cnt,
  output logic             fall,
  output logic             finished,
  output logic             no_start,
  output logic [31:0]      v0_capt,
  output logic [CNT_W-1:0] cyc_capt
);

  logic prev_active;
  logic seen;

  assign fall = sample && prev_active && !active && !finished;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: capture registers are reset too because their zero value is visible at the outputs.
    if (!rst_n) begin
      prev_active <= 1'b0;
      seen        <= 1'b0;
      finished    <= 1'b0;
      no_start    <= 1'b0;
      v0_capt     <= '0;
      cyc_capt    <= '0;
    end else if (clear) begin
      prev_active <= 1'b0;
      seen        <= 1'b0;
      finished    <= 1'b0;
      no_start    <= 1'b0;
      v0_capt     <= '0;
      cyc_capt    <= '0;
    end else if (sample) begin
      // NOTE: non-blocking, so fall above always sees the pre-edge prev_active and finished.
      prev_active <= active;
      if (active) seen <= 1'b1;
      if (start_chk && !seen && !active) no_start <= 1'b1;
      if (fall) begin
        finished <= 1'b1;
        v0_capt  <= v0;
        cyc_capt <= cnt;
      end
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Sequences reset / run / completion of a group of CPUs and records per-CPU
// completion data; holds the run FSM and the reset and run cycle counters.
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int NUM_CPUS       = DEF_NUM_CPUS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int START_WAIT     = DEF_START_WAIT,
  parameter int CNT_W          = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 rst_n,
  cpu_run_controller_if.slave bus
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  run_state_e                state;
  run_state_e                state_nxt;
  logic [RC_W-1:0]           rst_cnt;
  logic [CNT_W-1:0]          cnt;
  logic                      run_en;
  logic                      accept_start;
  logic                      start_chk;
  logic                      all_fin_nxt;
  logic [NUM_CPUS-1:0]       fall;
  logic [NUM_CPUS-1:0]       finished;
  logic [NUM_CPUS-1:0]       no_start;
  logic [32*NUM_CPUS-1:0]    v0_capt;
  logic [CNT_W*NUM_CPUS-1:0] cyc_capt;

  // Falls are only observed on cycles where the CPUs actually advance.
  assign run_en       = (state == ST_RUN) && !bus.pause && !bus.abort;
  assign accept_start = can_start(state) && bus.start && !bus.abort;
  assign start_chk    = run_en && (cnt == CNT_W'(START_WAIT - 1));
  assign all_fin_nxt  = &(finished | fall);

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_TIMEOUT: if (bus.start) state_nxt = ST_RESET;
        ST_RESET: if (rst_cnt == RC_W'(RESET_CYCLES - 1)) state_nxt = ST_RUN;
        ST_RUN: begin
          // Completion is checked before timeout so a last fall at the limit still wins.
          if (run_en) begin
            if (all_fin_nxt)                            state_nxt = ST_DONE;
            else if (cnt == CNT_W'(TIMEOUT_CYCLES))     state_nxt = ST_TIMEOUT;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rst_cnt <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (accept_start) begin
        rst_cnt <= '0;
        cnt     <= '0;
      end else begin
        if (state == ST_RESET) rst_cnt <= rst_cnt + 1'b1;
        if (run_en && (cnt != '1)) cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CPUS; i++) begin : g_ch
    run_channel_monitor #(.CNT_W(CNT_W)) u_mon (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (accept_start),
      .sample    (run_en),
      .start_chk (start_chk),
      .active    (bus.active[i]),
      .v0        (bus.register_v0[32*i +: 32]),
      .cnt       (cnt),
      .fall      (fall[i]),
      .finished  (finished[i]),
      .no_start  (no_start[i]),
      .v0_capt   (v0_capt[32*i +: 32]),
      .cyc_capt  (cyc_capt[CNT_W*i +: CNT_W])
    );
  end

  assign bus.cpu_rst    = (state == ST_IDLE) || (state == ST_RESET);
  assign bus.clk_enable = (state == ST_RESET) || ((state == ST_RUN) && !bus.pause);
  assign bus.done       = (state == ST_DONE);
  assign bus.timeout    = (state == ST_TIMEOUT);
  assign bus.start_err  = |no_start;
  assign bus.finished   = finished;
  assign bus.v0_capt    = v0_capt;
  assign bus.cyc_capt   = cyc_capt;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench: each run is described by per-channel rise/fall counter
// values and the expected result is derived from those schedules.
module tb_cpu_run_controller;

  localparam int N     = 2;
  localparam int TO    = 40;
  localparam int RC    = 2;
  localparam int SW    = 4;
  localparam int CW    = 16;
  localparam int NEVER = 100000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cpu_run_controller_if #(.NUM_CPUS(N), .CNT_W(CW)) bus ();

  cpu_run_controller #(
    .NUM_CPUS(N), .TIMEOUT_CYCLES(TO), .RESET_CYCLES(RC), .START_WAIT(SW), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Run description: channel i is active for RUN counters rise..fall-1.
  int          rise      [N];
  int          fall_at   [N];
  logic [31:0] v0_fixed  [N];
  bit          use_fixed;
  int          pause_pct;
  int          stop_at;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " cpu_rst"},    bus.cpu_rst,    64'd1);
    check({tag, " clk_enable"}, bus.clk_enable, 64'd0);
    check({tag, " finished"},   bus.finished,   64'd0);
    check({tag, " v0_capt"},    bus.v0_capt,    64'd0);
    check({tag, " cyc_capt"},   bus.cyc_capt,   64'd0);
    check({tag, " done"},       bus.done,       64'd0);
    check({tag, " timeout"},    bus.timeout,    64'd0);
    check({tag, " start_err"},  bus.start_err,  64'd0);
  endtask

  task automatic launch(input string name);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.active = '0;
    @(negedge clk);
    bus.start = 1'b0;
    check({name, " rst cpu_rst"},    bus.cpu_rst,    64'd1);
    check({name, " rst clk_enable"}, bus.clk_enable, 64'd1);
    check({name, " rst finished"},   bus.finished,   64'd0);
    check({name, " rst start_err"},  bus.start_err,  64'd0);
    check({name, " rst done"},       bus.done | bus.timeout, 64'd0);
    repeat (RC) @(negedge clk);
  endtask

  task automatic run_one(input string name);
    int          k;
    bit          paused;
    bit          fin_all;
    bit          ended;
    bit          exp_err;
    bit          exp_f;
    logic [31:0] cur_v0 [N];
    logic [31:0] cap_v0 [N];
    logic [N-1:0] exp_fin;
    exp_err = 1'b0;
    fin_all = 1'b0;
    for (int i = 0; i < N; i++) begin
      cap_v0[i] = '0;
      if (rise[i] >= SW) exp_err = 1'b1;
    end
    launch(name);
    k     = 0;
    ended = 1'b0;
    for (int iter = 0; iter < 400 && !ended; iter++) begin
      if (k == stop_at) begin
        bus.pause = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values({name, " async"});
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      for (int i = 0; i < N; i++) exp_fin[i] = (fall_at[i] < k);
      check({name, " run finished"},  bus.finished,  64'(exp_fin));
      check({name, " run start_err"}, bus.start_err, 64'(exp_err && (k >= SW)));
      check({name, " run flags"},     {bus.done, bus.timeout, bus.cpu_rst}, 64'd0);
      paused    = ($urandom_range(0, 99) < pause_pct);
      bus.pause = paused;
      bus.start = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        bus.active[i] = (k >= rise[i]) && (k < fall_at[i]);
        cur_v0[i]     = use_fixed ? v0_fixed[i] : $urandom;
        bus.register_v0[32*i +: 32] = cur_v0[i];
      end
      #1 check({name, " run clk_enable"}, bus.clk_enable, 64'(!paused));
      if (!paused) begin
        fin_all = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (fall_at[i] == k) cap_v0[i] = cur_v0[i];
          if (fall_at[i] > k)  fin_all   = 1'b0;
        end
        if (fin_all || k == TO) ended = 1'b1;
        else                    k++;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
    check({name, " ended in budget"}, ended, 64'd1);
    check({name, " end done"},       bus.done,       64'(fin_all));
    check({name, " end timeout"},    bus.timeout,    64'(!fin_all));
    check({name, " end clk_enable"}, bus.clk_enable, 64'd0);
    check({name, " end cpu_rst"},    bus.cpu_rst,    64'd0);
    check({name, " end start_err"},  bus.start_err,  64'(exp_err));
    for (int i = 0; i < N; i++) begin
      exp_f = (fall_at[i] <= k);
      check({name, " end finished bit"}, bus.finished[i], 64'(exp_f));
      check({name, " end cyc_capt"}, bus.cyc_capt[CW*i +: CW], exp_f ? 64'(fall_at[i]) : 64'd0);
      check({name, " end v0_capt"},  bus.v0_capt[32*i +: 32],  exp_f ? 64'(cap_v0[i]) : 64'd0);
    end
    @(negedge clk);
    check({name, " hold end state"}, {bus.done, bus.timeout}, 64'({fin_all, !fin_all}));
  endtask

  task automatic set_run(input int r0, input int f0, input int r1, input int f1);
    rise[0] = r0; fall_at[0] = f0;
    rise[1] = r1; fall_at[1] = f1;
  endtask

  task automatic pause_test();
    launch("pause");
    bus.active = 2'b11;
    repeat (5) @(negedge clk);
    for (int c = 5; c <= 9; c++) begin
      bus.pause = 1'b1;
      if (c >= 7) bus.active[0] = 1'b0;
      #1 check("pause clk_enable", bus.clk_enable, 64'd0);
      @(negedge clk);
      check("pause no capture", bus.finished, 64'd0);
    end
    bus.pause       = 1'b0;
    bus.active[1]   = 1'b0;
    bus.register_v0 = {32'h1234_5678, 32'h0000_0000};
    @(negedge clk);
    check("pause ch1 finished", bus.finished[1],   64'd1);
    check("pause frozen count", bus.cyc_capt[CW +: CW], 64'd5);
    check("pause ch1 v0",       bus.v0_capt[32 +: 32],  64'h1234_5678);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check("abort cpu_rst",    bus.cpu_rst,    64'd1);
    check("abort clk_enable", bus.clk_enable, 64'd0);
    check("abort done",       bus.done,       64'd0);
    check("abort retained",   bus.cyc_capt[CW +: CW], 64'd5);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("idle after abort", {bus.cpu_rst, bus.clk_enable}, 64'b10);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.pause       = 1'b0;
    bus.active      = '0;
    bus.register_v0 = '0;
    use_fixed = 1'b0;
    pause_pct = 0;
    stop_at   = -1;
    #1 rst_n = 1'b0;
    #1 check_reset_values("reset");
    #10 rst_n = 1'b1;
    @(negedge clk);
    check("idle cpu_rst", bus.cpu_rst, 64'd1);

    use_fixed   = 1'b1;
    v0_fixed[0] = 32'h0000_0005;
    v0_fixed[1] = 32'hDEAD_BEEF;
    set_run(0, 10, 0, 14);
    run_one("two_done");

    pause_pct = 20;
    set_run(0, 12, 0, NEVER);
    run_one("ch1_timeout");

    set_run(0, 8, NEVER, NEVER);
    run_one("start_err");

    pause_pct = 0;
    set_run(0, 5, 0, TO);
    run_one("done_at_limit");

    pause_test();

    use_fixed = 1'b0;
    stop_at   = 6;
    set_run(0, 3, 5, 20);
    run_one("midrun_rst");
    stop_at = -1;

    pause_pct = 20;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          rise[i]    = NEVER;
          fall_at[i] = NEVER;
        end else begin
          rise[i]    = $urandom_range(0, 5);
          fall_at[i] = rise[i] + 1 + $urandom_range(0, 44);
        end
      end
      run_one("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t expected below 1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_run_controller.md
CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 Parameter NUM_CPUS, 2, number of CPU channels supervised (1..8).
REQ-002 Parameter TIMEOUT_CYCLES, 40, maximum enabled RUN cycles before timeout (>=1).
REQ-003 Parameter RESET_CYCLES, 2, cycles cpu_rst is held high per run (>=1).
REQ-004 Parameter START_WAIT, 4, RUN cycles within which every channel SHALL raise active.
REQ-005 Parameter CNT_W, 16, cycle-counter width; TIMEOUT_CYCLES SHALL be < 2**CNT_W.
REQ-006 clk  in  1  single system clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset of this block.
REQ-008 start  in  1  one-cycle pulse; begins a run from IDLE, DONE or TIMEOUT.
REQ-009 abort  in  1  level; forces IDLE from any state.
REQ-010 pause  in  1  level; freezes the run while high.
REQ-011 active  in  NUM_CPUS  per-CPU active flag.
REQ-012 register_v0  in  32*NUM_CPUS  per-CPU v0, channel i at bits [32*i+31:32*i].
REQ-013 cpu_rst  out  1  active-high reset driven to all CPUs.
REQ-014 clk_enable  out  1  clock enable driven to all CPUs.
REQ-015 finished  out  NUM_CPUS  per-channel sticky completion flag.
REQ-016 v0_capt  out  32*NUM_CPUS  v0 captured at completion, same packing as register_v0.
REQ-017 cyc_capt  out  CNT_W*NUM_CPUS  RUN cycle count at completion per channel.
REQ-018 done  out  1  high in DONE; timeout  out  1  high in TIMEOUT; start_err  out  1  sticky, some channel never became active.

Function
REQ-019 States IDLE, RESET, RUN, DONE, TIMEOUT; encoding is an enum in the package.
REQ-020 IDLE/DONE/TIMEOUT + start -> RESET; clears finished, v0_capt, cyc_capt, start_err, cycle counter.
REQ-021 RESET: cpu_rst=1, clk_enable=1 for exactly RESET_CYCLES cycles, then RUN.
REQ-022 RUN: cpu_rst=0; clk_enable = !pause; cycle counter increments only when clk_enable=1.
REQ-023 active sampled each RUN cycle with clk_enable=1; falling edge (prev 1, now 0) on channel i with finished[i]=0 SHALL set finished[i] and capture register_v0 slice and current counter in the same edge.
REQ-024 Falling edges while paused are ignored; the previous-active register holds while paused.
REQ-025 A channel never seen active by counter == START_WAIT SHALL set start_err; the run continues.
REQ-026 RUN -> DONE on the cycle all finished bits are (or become) set; clk_enable=0 in DONE.
REQ-027 RUN -> TIMEOUT when counter reaches TIMEOUT_CYCLES with any finished bit clear; clk_enable=0, captured values for finished channels retained.
REQ-028 Simultaneous last completion and timeout in one cycle: DONE wins.
REQ-029 start while in RESET or RUN is ignored.
REQ-030 abort has priority over start and all transitions; next state IDLE, cpu_rst=1, clk_enable=0, flags retained.
REQ-031 Counter saturates at 2**CNT_W-1; never wraps.

Reset
REQ-032 rst low asynchronously: state IDLE, cpu_rst=1, clk_enable=0, finished=0, v0_capt=0, cyc_capt=0, done=0, timeout=0, start_err=0, counter=0.
REQ-033 rst low mid-run discards the run; no capture occurs on the reset edge.

Structure
REQ-034 Package cpu_run_pkg holds the state enum and default parameter constants.
REQ-035 One sub-module, run_channel_monitor, instantiated NUM_CPUS times: edge detect, seen-active flag, capture registers.
REQ-036 Top holds the FSM, reset-cycle counter and run cycle counter only.

Verification
REQ-037 NUM_CPUS=2; start; ch0 active 1->0 at RUN cycle 10 with v0=0x0000_0005, ch1 at 14 with v0=0xDEAD_BEEF -> finished=2'b11, cyc_capt 10/14, done=1 next cycle, clk_enable=0.
REQ-038 ch1 never falls, TIMEOUT_CYCLES=40 -> timeout=1 at counter 40, ch0 captures retained, finished=2'b01.
REQ-039 pause high RUN cycles 5-9, ch0 falls at cycle 7 and stays low -> no capture; counter frozen at 5 for those cycles.
REQ-040 ch1 active held 0 -> start_err=1 at counter 4; run still reaches timeout or done.
REQ-041 rst low at RUN cycle 6 -> all outputs at reset values within same cycle; following start runs cleanly.
REQ-042 last fall and counter==TIMEOUT_CYCLES same cycle -> done=1, timeout=0.
